// File: rtl/edicion_de_parametros.sv
// Push-button editor for the nine packed-BCD RTC parameters, with write requests on leaving edit mode.
// Define DIA_MES_LIMITE_EN to make the day limit follow the month and leap year, clamping d when me or a change.
module edicion_de_parametros #(
    parameter int WAIT_MAX = 1024,
    parameter int WAIT_W   = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       edit,
    input  logic       sel,
    input  logic       up,
    input  logic       down,
    input  logic       forma,
    input  logic       Listo_es,
    output logic [7:0] s,
    output logic [7:0] m,
    output logic [7:0] h,
    output logic [7:0] d,
    output logic [7:0] me,
    output logic [7:0] a,
    output logic [7:0] st,
    output logic [7:0] mt,
    output logic [7:0] ht,
    output logic [3:0] campo,
    output logic       editando,
    output logic       Ld_1,
    output logic       Ld_2,
    output logic       timeout
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EDIT = 2'd1;
    localparam logic [1:0] REQ  = 2'd2;
    localparam logic [1:0] WAIT = 2'd3;

    logic [1:0]        state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              dirty_1, dirty_2;
    logic              sel_q, up_q, down_q;
    logic              sel_e, up_e, down_e, step;
    logic [7:0]        cur, lo, hi, nxt, dia_max;
    logic [7:0]        d_next, me_next, a_next;

    // Values outside [lo, hi] snap to lo when going up and to hi when going down.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lo_v, input logic [7:0] hi_v);
        if (v < lo_v || v >= hi_v) return lo_v;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return v + 8'd1;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] lo_v, input logic [7:0] hi_v);
        if (v <= lo_v || v > hi_v) return hi_v;
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        return v - 8'd1;
    endfunction

`ifdef DIA_MES_LIMITE_EN
    // A BCD year 10T+U is a multiple of 4 exactly when 2*T[0] + U[1:0] is.
    function automatic logic [7:0] dia_lim(input logic [7:0] mes, input logic [7:0] anio);
        logic [1:0] r;
        r = {anio[4], 1'b0} + anio[1:0];
        case (mes)
            8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
            8'h02:                      return (r == 2'd0) ? 8'h29 : 8'h28;
            default:                    return 8'h31;
        endcase
    endfunction
`endif

    always_comb begin
        sel_e = sel & ~sel_q;
        up_e  = up & ~up_q;
        down_e = down & ~down_q;
        step  = (state == EDIT) && (up_e ^ down_e);
`ifdef DIA_MES_LIMITE_EN
        dia_max = dia_lim(me, a);
`else
        dia_max = 8'h31;
`endif
        cur = 8'h00;
        lo  = 8'h00;
        hi  = 8'h00;
        case (campo)
            4'd0: begin cur = s;  hi = 8'h59; end
            4'd1: begin cur = m;  hi = 8'h59; end
            4'd2: begin cur = h;  lo = forma ? 8'h01 : 8'h00; hi = forma ? 8'h12 : 8'h23; end
            4'd3: begin cur = d;  lo = 8'h01; hi = dia_max; end
            4'd4: begin cur = me; lo = 8'h01; hi = 8'h12; end
            4'd5: begin cur = a;  hi = 8'h99; end
            4'd6: begin cur = st; hi = 8'h59; end
            4'd7: begin cur = mt; hi = 8'h59; end
            4'd8: begin cur = ht; hi = 8'h23; end
            default: begin cur = 8'h00; end
        endcase
        nxt     = up_e ? bcd_inc(cur, lo, hi) : bcd_dec(cur, lo, hi);
        me_next = (step && campo == 4'd4) ? nxt : me;
        a_next  = (step && campo == 4'd5) ? nxt : a;
        d_next  = (step && campo == 4'd3) ? nxt : d;
`ifdef DIA_MES_LIMITE_EN
        if (step && (campo == 4'd4 || campo == 4'd5) && d > dia_lim(me_next, a_next))
            d_next = dia_lim(me_next, a_next);
`endif
    end

    // Edge detectors always track the raw levels, so reset preloads them too.
    always_ff @(posedge clk) begin
        sel_q  <= sel;
        up_q   <= up;
        down_q <= down;
        if (rst) begin
            state    <= IDLE;
            campo    <= 4'd0;
            dirty_1  <= 1'b0;
            dirty_2  <= 1'b0;
            wait_cnt <= '0;
            s  <= 8'h00;
            m  <= 8'h00;
            h  <= forma ? 8'h12 : 8'h00;
            d  <= 8'h01;
            me <= 8'h01;
            a  <= 8'h00;
            st <= 8'h00;
            mt <= 8'h00;
            ht <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (edit) begin
                        state   <= EDIT;
                        campo   <= 4'd0;
                        dirty_1 <= 1'b0;
                        dirty_2 <= 1'b0;
                    end
                end
                EDIT: begin
                    d  <= d_next;
                    me <= me_next;
                    a  <= a_next;
                    if (step) begin
                        case (campo)
                            4'd0: s  <= nxt;
                            4'd1: m  <= nxt;
                            4'd2: h  <= nxt;
                            4'd6: st <= nxt;
                            4'd7: mt <= nxt;
                            4'd8: ht <= nxt;
                            default: ;
                        endcase
                        if (campo <= 4'd5) dirty_1 <= 1'b1;
                        else               dirty_2 <= 1'b1;
                    end
                    if (sel_e) campo <= (campo == 4'd8) ? 4'd0 : campo + 4'd1;
                    if (!edit) state <= REQ;
                end
                REQ: begin
                    if (dirty_1 || dirty_2) begin
                        state    <= WAIT;
                        wait_cnt <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    if (Listo_es || wait_cnt == WAIT_W'(WAIT_MAX - 1)) state <= IDLE;
                    else wait_cnt <= wait_cnt + WAIT_W'(1);
                end
            endcase
        end
    end

    assign editando = (state == EDIT);
    assign Ld_1     = (state == REQ) && dirty_1;
    assign Ld_2     = (state == REQ) && dirty_2;
    assign timeout  = (state == WAIT) && !Listo_es && (wait_cnt == WAIT_W'(WAIT_MAX - 1));

endmodule

// File: doc/edicion_de_parametros.md
Name: edicion_de_parametros

Overview:
- Upstream user-edit stage for the RTC write path. Turns debounced push-button levels (up, down, sel) into nine 8-bit packed-BCD parameters: s, m, h, d, me, a, st, mt, ht.
- On leaving edit mode it issues one-cycle write requests: Ld_1 for time/date, Ld_2 for timer. It then waits for the writer's done flag (Listo_es).
- Sits between the button conditioning logic and the parameter-writing bus engine.

Parameters:
- WAIT_MAX, 1024: clk cycles to wait for Listo_es before abandoning a request.
- WAIT_W, 11: width of the wait counter; must hold WAIT_MAX.

Ports:
- clk  input  1  system clock; every flop updates on its rising edge.
- rst  input  1  synchronous reset, active high.
- edit  input  1  level; high = edit mode requested.
- sel  input  1  debounced level; each rising edge advances to the next field.
- up  input  1  debounced level; each rising edge increments the current field.
- down  input  1  debounced level; each rising edge decrements the current field.
- forma  input  1  hour format: 0 = 24 h, 1 = 12 h.
- Listo_es  input  1  write-complete flag from the writer.
- s, m, h, d, me, a, st, mt, ht  output  8 each  BCD parameters; these are registers.
- campo  output  4  index of the field being edited, 0..8 = s, m, h, d, me, a, st, mt, ht.
- editando  output  1  high in state EDIT.
- Ld_1  output  1  one-cycle request to write time/date.
- Ld_2  output  1  one-cycle request to write timer.
- timeout  output  1  one-cycle pulse when the wait for Listo_es expires.

Behaviour:
- Reset, synchronous active-high:
  - State = IDLE; campo = 0; editando, Ld_1, Ld_2, timeout = 0; dirty flags cleared.
  - s, m, st, mt, ht, a = 8'h00; d = 8'h01; me = 8'h01.
  - h = 8'h12 if forma = 1, else 8'h00.
  - Edge detectors are preloaded with the current input levels, so no spurious edge appears after reset.
  - Reset mid-operation aborts any pending request.
- Edge detection: rising edge = input high this cycle and low in the registered copy from the previous cycle. A field changes one cycle after the edge cycle.
- IDLE:
  - edit = 1 moves to EDIT; campo = 0; both dirty flags cleared.
  - Buttons are ignored.
- EDIT (editando = 1):
  - sel edge: campo increments 0..8, then wraps 8 -> 0.
  - up edge alone: the field increments in BCD.
  - down edge alone: the field decrements in BCD.
  - up and down edges in the same cycle: no change.
  - sel edge together with up/down in the same cycle: the value changes first, for the old campo; campo advances in that same cycle.
  - Any up/down change on campo 0..5 sets dirty_1; on campo 6..8 sets dirty_2.
  - edit = 0 moves to REQ.
- Field limits; the value wraps both ways (max + 1 -> min, min - 1 -> max):
  - s, m, st, mt: 00..59.
  - ht: 00..23.
  - h: 00..23 when forma = 0; 01..12 when forma = 1.
  - d: 01..31.
  - me: 01..12.
  - a: 00..99.
- Out-of-range value (e.g. h = 8'h17 after forma switches to 1): up loads min; down loads max.
- BCD arithmetic: the low nibble rolls 9 -> 0 with a carry; borrow rolls 0 -> 9.
- REQ (lasts one cycle):
  - Ld_1 = dirty_1 and Ld_2 = dirty_2, both asserted in the same cycle.
  - If neither flag is set, go to IDLE; otherwise go to WAIT and clear the wait counter.
- WAIT:
  - Outputs stay frozen; buttons are ignored.
  - Listo_es = 1 -> IDLE.
  - Wait counter reaches WAIT_MAX - 1 -> pulse timeout for one cycle, then IDLE.
  - edit re-asserted during WAIT is ignored until IDLE; the IDLE -> EDIT move then follows on the next cycle.

Optional Feature:
- Macro: DIA_MES_LIMITE_EN.
- Defined: the upper limit of d depends on me.
  - me = 04, 06, 09, 11: limit 30.
  - me = 02: limit 29 if the BCD year a is divisible by 4, else 28.
  - All other months: limit 31.
  - Changing me or a clamps d to the new limit in the same cycle.
- Undefined: d is always limited to 01..31 and is never clamped.

Test Plan:
- Reset with forma = 0, then edit = 1, three up edges on campo 0 (s) -> s = 8'h03, editando = 1, campo = 0.
- s = 8'h59, one up edge -> s = 8'h00. Then sel twice, down once on campo 2 (h) with forma = 0 -> h = 8'h23.
- forma = 1, h = 8'h17, up edge -> h = 8'h01; a subsequent down edge -> h = 8'h12.
- Edit me (campo 4) from 8'h01 to 8'h02, then drop edit -> Ld_1 pulses exactly 1 cycle, Ld_2 = 0. Listo_es asserted 5 cycles later -> IDLE next cycle.
- Edit only st (campo 6), drop edit, Listo_es never asserted -> Ld_2 pulse, then timeout pulse WAIT_MAX cycles later, state IDLE.
- DIA_MES_LIMITE_EN defined, a = 8'h16, d = 8'h31, me changed 01 -> 02 -> d = 8'h29. Assert rst mid-WAIT -> all outputs return to reset values the next cycle.
